// File: rtl/data_memory_responder_if.sv
// Handshake bundle between the datapath data port and the memory responder.
// master: datapath side; slave: responder side.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output busy
  );
endinterface

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder: word RAM, fixed wait latency,
// alignment/range error check. Ports: clk, reset (async, active-low), bus.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  err;
  logic [ADDR_WIDTH-1:0] idx;

  assign accept = (state == IDLE) && bus.req_valid;
  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign idx    = cap_addr[ADDR_WIDTH+1:2];

  // Upper bits must be zero so large addresses never alias onto the RAM.
  assign err = (cap_addr[1:0] != 2'b00) ||
               ((cap_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_nx = WAIT;
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q   <= err;
        rdata_q <= (!err && !cap_we) ? mem[idx] : 32'd0;
      end
    end
  end

  // RAM is outside the reset domain; an aborted request never
  // reaches commit because reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (commit && !err && cap_we) begin
      mem[idx] <= cap_wdata;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder.
// Three instances (LATENCY 1, 2, 15) share clk/reset behind one driver.
module tb_data_memory_responder;

  logic clk;
  logic rst_n;

  int drv_sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_busy;

  int n_checks;
  int n_errors;

  logic [31:0] ref_mem [3][256];
  bit          ref_wr  [3][256];

  data_memory_responder_if b0();
  data_memory_responder_if b1();
  data_memory_responder_if b2();

  data_memory_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut0 (
    .clk(clk), .reset(rst_n), .bus(b0.slave)
  );
  data_memory_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut1 (
    .clk(clk), .reset(rst_n), .bus(b1.slave)
  );
  data_memory_responder #(.ADDR_WIDTH(8), .LATENCY(15)) dut2 (
    .clk(clk), .reset(rst_n), .bus(b2.slave)
  );

  assign b0.req_valid = (drv_sel == 0) ? req_valid : 1'b0;
  assign b1.req_valid = (drv_sel == 1) ? req_valid : 1'b0;
  assign b2.req_valid = (drv_sel == 2) ? req_valid : 1'b0;
  assign b0.req_we    = req_we;
  assign b1.req_we    = req_we;
  assign b2.req_we    = req_we;
  assign b0.req_addr  = req_addr;
  assign b1.req_addr  = req_addr;
  assign b2.req_addr  = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b2.req_wdata = req_wdata;

  always_comb begin
    obs_ready = b1.req_ready;
    obs_valid = b1.rsp_valid;
    obs_rdata = b1.rsp_rdata;
    obs_err   = b1.rsp_err;
    obs_busy  = b1.busy;
    case (drv_sel)
      0: begin
        obs_ready = b0.req_ready;
        obs_valid = b0.rsp_valid;
        obs_rdata = b0.rsp_rdata;
        obs_err   = b0.rsp_err;
        obs_busy  = b0.busy;
      end
      2: begin
        obs_ready = b2.req_ready;
        obs_valid = b2.rsp_valid;
        obs_rdata = b2.rsp_rdata;
        obs_err   = b2.rsp_err;
        obs_busy  = b2.busy;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int s);
    case (s)
      0: return 1;
      1: return 2;
      default: return 15;
    endcase
  endfunction

  // Reference: error by plain arithmetic, RAM as an array of words.
  task automatic model(input int s, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output bit e, output logic [31:0] rd,
                       output bit known);
    logic [7:0] i;
    e = (addr % 4 != 0) || (addr / 4 >= 256);
    rd = 32'd0;
    known = 1'b1;
    i = addr[9:2];
    if (!e) begin
      if (we) begin
        ref_mem[s][i] = wd;
        ref_wr[s][i] = 1'b1;
      end else begin
        rd = ref_mem[s][i];
        known = ref_wr[s][i];
      end
    end
  endtask

  // Presents one request and returns at the first falling edge after
  // its acceptance edge, with req_valid dropped.
  task automatic start_req(input int s, input bit we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output bit ok);
    int n;
    drv_sel = s;
    req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!obs_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = obs_ready;
    if (!ok) begin
      chk("ready_timeout", 32'(obs_ready), 32'd1);
      return;
    end
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input int s, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    bit e;
    bit known;
    logic [31:0] rd;
    int lat;
    lat = lat_of(s);
    start_req(s, we, addr, wd, ok);
    if (!ok) return;
    model(s, we, addr, wd, e, rd, known);
    for (int k = 1; k <= lat; k++) begin
      chk("wait_vld", 32'(obs_valid), 32'd0);
      chk("wait_rdy", 32'(obs_ready), 32'd0);
      chk("wait_busy", 32'(obs_busy), 32'd1);
      req_valid = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      req_we = 1'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("rsp_vld", 32'(obs_valid), 32'd1);
    chk("rsp_err", 32'(obs_err), 32'(e));
    if (known) chk("rsp_rdata", obs_rdata, rd);
    @(negedge clk);
    chk("rsp_1cyc", 32'(obs_valid), 32'd0);
    chk("idle_rdy", 32'(obs_ready), 32'd1);
    chk("idle_busy", 32'(obs_busy), 32'd0);
    chk("hold_err", 32'(obs_err), 32'(e));
    if (known) chk("hold_rdata", obs_rdata, rd);
  endtask

  // req_valid held high; stores on even slots, loads of the same
  // address on odd slots. Accepts must land every lat+2 cycles.
  task automatic burst(input int s, input int ntx, input bit fixed);
    int lat;
    int period;
    int phase;
    int k;
    int n;
    bit e;
    bit known;
    logic [31:0] rd;
    logic [31:0] a;
    lat = lat_of(s);
    period = lat + 2;
    drv_sel = s;
    req_valid = 1'b0;
    a = 32'd4;
    e = 1'b0;
    known = 1'b0;
    rd = 32'd0;
    @(negedge clk);
    n = 0;
    while (!obs_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!obs_ready) begin
      chk("bst_timeout", 32'(obs_ready), 32'd1);
      return;
    end
    for (int c = 0; c < ntx * period; c++) begin
      phase = c % period;
      k = c / period;
      if (phase == 0) begin
        chk("bst_rdy_hi", 32'(obs_ready), 32'd1);
        if (k % 2 == 0) begin
          a = fixed ? 32'd4 : {22'd0, 8'($urandom), 2'b00};
          req_we = 1'b1;
          req_wdata = fixed ? 32'hA5A5A5A5 : $urandom;
        end else begin
          req_we = 1'b0;
          req_wdata = $urandom;
        end
        req_addr = a;
        req_valid = 1'b1;
        model(s, req_we, a, req_wdata, e, rd, known);
      end else begin
        chk("bst_rdy_lo", 32'(obs_ready), 32'd0);
      end
      chk("bst_vld", 32'(obs_valid), 32'(phase == lat + 1));
      if (phase == lat + 1) begin
        chk("bst_err", 32'(obs_err), 32'(e));
        if (known) chk("bst_rdata", obs_rdata, rd);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bst_end_rdy", 32'(obs_ready), 32'd1);
  endtask

  initial begin
    bit ok;
    logic [31:0] a;
    n_checks = 0;
    n_errors = 0;
    drv_sel = 1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) begin
        ref_mem[s][i] = 32'd0;
        ref_wr[s][i] = 1'b0;
      end
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      drv_sel = s;
      #1;
      chk("rst_rdy", 32'(obs_ready), 32'd1);
      chk("rst_busy", 32'(obs_busy), 32'd0);
      chk("rst_vld", 32'(obs_valid), 32'd0);
      chk("rst_rdata", obs_rdata, 32'd0);
      chk("rst_err", 32'(obs_err), 32'd0);
    end
    drv_sel = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("quiet_vld", 32'(obs_valid), 32'd0);
      chk("quiet_rdy", 32'(obs_ready), 32'd1);
    end

    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1, 1'b0, 32'h10, 32'h0);
    do_req(1, 1'b0, 32'h13, 32'h0);
    do_req(1, 1'b1, 32'h0, 32'h12345678);
    do_req(1, 1'b1, 32'h400, 32'h87654321);
    do_req(1, 1'b0, 32'h0, 32'h0);
    do_req(1, 1'b1, 32'h3FC, 32'h0BADF00D);
    do_req(1, 1'b0, 32'h3FC, 32'h0);
    do_req(1, 1'b1, 32'hFFFFFFFC, 32'h77777777);
    do_req(1, 1'b0, 32'hFFFFFFFC, 32'h0);
    do_req(1, 1'b0, 32'h0, 32'h0);

    burst(1, 6, 1'b0);

    // Abort: reset lands in WAIT, store must never reach the RAM.
    do_req(1, 1'b1, 32'h20, 32'h11111111);
    start_req(1, 1'b1, 32'h20, 32'hCAFEF00D, ok);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(obs_ready), 32'd1);
    chk("abort_vld", 32'(obs_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_novld", 32'(obs_valid), 32'd0);
    end
    rst_n = 1'b1;
    do_req(1, 1'b0, 32'h20, 32'h0);

    // Reset in RESP: the committed store survives.
    start_req(1, 1'b1, 32'h30, 32'h5A5A0001, ok);
    begin
      bit e;
      bit known;
      logic [31:0] rd;
      model(1, 1'b1, 32'h30, 32'h5A5A0001, e, rd, known);
    end
    @(negedge clk);
    @(negedge clk);
    chk("resp_vld", 32'(obs_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_vld", 32'(obs_valid), 32'd0);
    chk("resp_rst_rdy", 32'(obs_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 1'b0, 32'h30, 32'h0);

    burst(0, 2, 1'b1);
    burst(2, 2, 1'b1);
    do_req(0, 1'b0, 32'h4, 32'h0);
    do_req(2, 1'b0, 32'h4, 32'h0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: a = {26'd0, 4'($urandom), 2'b00};
        1: a = {22'd0, 8'($urandom), 2'b00};
        2: a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        3: a = 32'h400 + {22'd0, 8'($urandom), 2'b00};
        4: a = 32'h3FC;
        default: a = $urandom;
      endcase
      do_req(int'($urandom_range(0, 2)), 1'($urandom), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the CPU's data port: accepts one load or store request at a time from the datapath (address = ALUResult, write data = WriteData) and returns read data (ReadData) after a programmable number of wait cycles. It holds a word-addressed synchronous RAM, checks alignment and range, and reports errors. It sits between the datapath/control unit and the data address space, and is the target for the multicycle CPU variant.

## Interface

Parameters:
- ADDR_WIDTH, 8, word-address bits; RAM depth = 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  input  1  request present.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept; high only in IDLE.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data, registered.
- rsp_err  output  1  request was misaligned or out of range, registered.
- busy  output  1  equals !req_ready.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. At a rising edge with req_valid=1, the request is accepted: capture req_we, req_addr and req_wdata; load the 4-bit counter cnt=LATENCY-1; go to WAIT. With req_valid=0, stay in IDLE.
- WAIT: req_ready=0. Inputs are ignored, and captured values are used. If cnt!=0, decrement and stay. If cnt==0, go to RESP and commit the access on that edge.
- Commit rules:
  - err = (addr[1:0]!=0) or (addr[31:ADDR_WIDTH+2]!=0).
  - Store with err=0: write mem[addr[ADDR_WIDTH+1:2]] = wdata; rsp_rdata=0.
  - Load with err=0: rsp_rdata = mem[index] as it stands before this edge. Any earlier committed store is therefore visible.
  - err=1: no write; rsp_rdata=0; rsp_err=1. Otherwise rsp_err=0.
- RESP: rsp_valid=1 for exactly this cycle; req_ready=0. The next edge goes to IDLE unconditionally.
- rsp_rdata and rsp_err hold their values until the next commit.
- RAM contents are not affected by reset. Contents are undefined until written.

## Timing

- Reset values:
  - State = IDLE.
  - req_ready=1.
  - busy=0.
  - rsp_valid=0.
  - rsp_rdata=0.
  - rsp_err=0.
  - cnt=0.
- Acceptance at edge a puts RESP at edge a+LATENCY; rsp_valid is high between edges a+LATENCY and a+LATENCY+1.
- The earliest next acceptance is edge a+LATENCY+2. The issue period is LATENCY+2 cycles.
- req_valid held high continuously produces back-to-back accepts at that period.
- Reset asserted mid-operation:
  - Asserted in WAIT: the request is aborted immediately, no RAM write occurs, rsp_valid is never issued, and the FSM is in IDLE after release.
  - Asserted in RESP: the write already committed stays; rsp_valid drops immediately.
- Address boundaries:
  - Address 4*(2^ADDR_WIDTH-1) is legal.
  - Address 4*2^ADDR_WIDTH is out of range and sets err.
  - Address 0xFFFFFFFC sets err; the index does not wrap.
- req_valid is sampled only in IDLE. Changes during WAIT or RESP have no effect.

## Test plan

Defaults ADDR_WIDTH=8, LATENCY=2 unless noted.

- Reset: reset=0 for 3 cycles, then release. Required: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; no response appears with req_valid=0.
- Store then load:
  - Store 0xDEADBEEF to 0x10, accepted at edge a. Required: rsp_valid in cycle a+2 with rsp_err=0.
  - Load 0x10 on the next accept. Required: rsp_rdata=0xDEADBEEF and rsp_err=0 two cycles after its acceptance.
- Errors:
  - Load 0x13. Required: rsp_err=1, rsp_rdata=0.
  - Store 0x400. Required: rsp_err=1, no write; a following load of 0x000 returns its previous value, e.g. 0x12345678 written earlier.
  - Load 0x3FC. Required: rsp_err=0.
- Throughput: req_valid held at 1 for 20 cycles with alternating store and load. Required: acceptances exactly every 4 cycles; req_ready low for 3 cycles after each acceptance; rsp_valid one cycle wide.
- Reset abort: store 0xCAFEF00D to 0x20, then assert reset during WAIT (cycle a+1). Required: no rsp_valid; after release, a load of 0x20 returns the prior contents (0x11111111), not 0xCAFEF00D.
- Latency sweep: LATENCY=1 and LATENCY=15, each with store then load of 0xA5A5A5A5 at 0x04. Required: rsp_valid exactly LATENCY cycles after acceptance, correct data, and period LATENCY+2.
